sdx_mailbox_fifo: RTL and testbench
===================================

# sdx_mailbox_fifo

Clocked, parametrised successor to the single-byte host/client mailbox. It sits between the Z80 host I/O bus (IN/OUT strobes, 8-bit port address) and the client controller's strobe bus. Each direction gets a DEPTH-entry FIFO instead of one shared byte. Host-to-client entries carry a per-byte command/data flag, and the block adds sticky overflow flags and client-controlled flushes.

## Interface
- DEPTH, 4: entries per FIFO; power of two, 2..64
- PORT_BASE, 5'b11000: match value for HostAddressBus[7:3]
- VERSION, 8'h20: value returned on the version port
- DETECT_ID, 8'd42: value returned on the detect port
- Clock  in  1  system clock, at least 8x the Z80 clock
- Reset  in  1  asynchronous, active-high; clears all state
- HostAddressBus  in  8  Z80 port address
- nIN, nOUT  in  1 each  Z80 I/O read/write strobes, active low, asynchronous
- HostDataIn  in  8  Z80 data bus, input side
- HostDataOut  out  8  read data to the Z80
- HostDataOE  out  1  top level drives the Z80 bus when 1
- ClientReadLine, ClientWriteLine, ClientStatusLine  in  1 each  client strobes, active high, asynchronous
- ClientDataIn  in  8  client data bus, input side
- ClientDataOut  out  8  read data to the client
- ClientDataOE  out  1  top level drives the client bus when 1
- ClientIrq  out  1  high while the H2C FIFO is non-empty

## Operation
- Port decode: hit = HostAddressBus[7:3]==PORT_BASE. Offset [2:0]:
  - 0 = write command, 1 = write data
  - 2 = read data, 4 = read status
  - 6 = detect, 7 = version
  - other offsets are ignored (no drive, no action)
- Client ops:
  - Write = Write & !Status; Read = Read & !Status
  - StatusRead = Status & Read; StatusWrite = Status & Write
- H2C FIFO, 9 bits wide: {cmd, byte}.
  - Host write at offset 0 pushes cmd=1; offset 1 pushes cmd=0.
- C2H FIFO, 8 bits wide.
- Push happens on the synchronised rising edge of the strobe, sampling the raw data bus. The data is stable by then.
- Pop happens on the synchronised falling edge, so data is held for the whole read.
- Read data and OE are combinational from the raw strobes, decode and FIFO head. There is no clock latency on reads.
- Reading an empty FIFO returns 8'hFF and has no pointer effect.
- Writing a full FIFO drops the byte and sets the sticky overflow flag for that writer: HostOvf or ClientOvf.
- Host status: {Top4[3:0], HostOvf, H2C head cmd, C2H non-empty, H2C full}.
  - The host status read clears HostOvf on its falling edge.
- Client status: {H2C count saturated to 15 [3:0], ClientOvf, H2C head cmd, C2H full, H2C non-empty}.
  - The client status read clears ClientOvf.
- Client status write:
  - Top4 <= data[7:4]
  - data[0]=1 flushes H2C; data[1]=1 flushes C2H
  - a flush clears the pointers and count only
- Detect returns DETECT_ID; version returns VERSION.

## Timing
- Every async strobe passes through a 2-FF synchroniser and then a 1-FF edge register.
  - Push or pop commits 3 Clock cycles after the strobe edge.
  - Minimum strobe width and minimum gap between strobes: 4 Clock cycles.
- Count width is $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
  - full = count==DEPTH; empty = count==0.
- Simultaneous push and pop on the same FIFO in one cycle:
  - both proceed and the count is unchanged
  - this holds when full, since the pop frees the slot
  - when empty, the push proceeds and the pop is ignored
- Flush in the same cycle as a push: the flush wins and the pushed byte is discarded.
- Overflow set and clear in the same cycle: set wins.
- Reset values:
  - pointers, counts, Top4, HostOvf, ClientOvf, synchronisers: 0
  - ClientIrq=0
  - HostDataOut/ClientDataOut follow the combinational decode (empty yields 8'hFF)
  - OE follows the raw strobes, even during Reset
- Reset mid-access: the access is abandoned and no push or pop occurs on release. A strobe still asserted at Reset release does not produce an edge.
- ClientIrq is registered and updates in the cycle after the count changes.

## Structure
- Shared package sdx_mailbox_pkg holds:
  - port offset constants
  - host and client status bit positions
  - the default DETECT_ID
- One sub-module, mailbox_fifo, instantiated twice:
  - parameters WIDTH, DEPTH
  - ports push/pop/flush, din, head, count, full, empty
  - Clock/Reset as above
- Synchroniser and edge detection live in a small generate loop in the top, not a separate module.

## Test plan
- Reset then host status read: returns 8'h00, and ClientIrq=0.
- Host writes 8'h55 at offset 0, then 8'hAA at offset 1:
  - ClientIrq rises
  - client status reads bit2=1 and count=2
  - client reads 55, then status bit2=0, then AA
  - ClientIrq then falls
- Client pushes DEPTH+1 bytes 0..DEPTH:
  - ClientOvf=1
  - host reads 0..DEPTH-1, then 8'hFF
  - host status bit1 goes to 0
- With H2C full, host write and client read overlap so they commit in the same cycle: count stays DEPTH, no overflow, FIFO order is preserved.
- Client status write 8'hA3:
  - Top4=A; both FIFOs empty
  - a pending same-cycle host push is discarded
  - host status reads 8'hA0
- Reset asserted while nIN is held low mid-read of a 3-entry C2H: after release C2H is empty, there is no spurious pop, and detect returns 42.

Source files
------------

// File: rtl/sdx_mailbox_fifo_pkg.sv
// Shared constants for the host/client mailbox: port offsets, status bit
// positions, strobe indices and the count-saturation helper.
package sdx_mailbox_pkg;

    localparam logic [2:0] OFF_WR_CMD  = 3'd0;
    localparam logic [2:0] OFF_WR_DATA = 3'd1;
    localparam logic [2:0] OFF_RD_DATA = 3'd2;
    localparam logic [2:0] OFF_STATUS  = 3'd4;
    localparam logic [2:0] OFF_DETECT  = 3'd6;
    localparam logic [2:0] OFF_VERSION = 3'd7;

    localparam int HS_H2C_FULL = 0;
    localparam int HS_C2H_NE   = 1;
    localparam int HS_HEAD_CMD = 2;
    localparam int HS_OVF      = 3;
    localparam int HS_TOP4_LSB = 4;

    localparam int CS_H2C_NE   = 0;
    localparam int CS_C2H_FULL = 1;
    localparam int CS_HEAD_CMD = 2;
    localparam int CS_OVF      = 3;
    localparam int CS_CNT_LSB  = 4;

    localparam logic [7:0] DEFAULT_DETECT_ID = 8'd42;
    localparam logic [7:0] EMPTY_READ        = 8'hFF;

    // Strobe indices into the synchroniser array, all in active-high sense.
    localparam int STB_HOST_RD = 0;
    localparam int STB_HOST_WR = 1;
    localparam int STB_CLI_RD  = 2;
    localparam int STB_CLI_WR  = 3;
    localparam int NUM_STB     = 4;

    function automatic logic [3:0] satCount4(input logic [6:0] c);
        return (c > 7'd15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/sdx_mailbox_fifo_if.sv
// Z80 host I/O bus plus client strobe bus as seen by the mailbox.
interface sdx_mailbox_fifo_if;
    logic [7:0] HostAddressBus;
    logic       nIN;
    logic       nOUT;
    logic [7:0] HostDataIn;
    logic [7:0] HostDataOut;
    logic       HostDataOE;
    logic       ClientReadLine;
    logic       ClientWriteLine;
    logic       ClientStatusLine;
    logic [7:0] ClientDataIn;
    logic [7:0] ClientDataOut;
    logic       ClientDataOE;
    logic       ClientIrq;

    modport master (
        output HostAddressBus, nIN, nOUT, HostDataIn,
        output ClientReadLine, ClientWriteLine, ClientStatusLine, ClientDataIn,
        input  HostDataOut, HostDataOE, ClientDataOut, ClientDataOE, ClientIrq
    );

    modport slave (
        input  HostAddressBus, nIN, nOUT, HostDataIn,
        input  ClientReadLine, ClientWriteLine, ClientStatusLine, ClientDataIn,
        output HostDataOut, HostDataOE, ClientDataOut, ClientDataOE, ClientIrq
    );
endinterface

// File: rtl/sdx_mailbox_fifo_fifo.sv
// Circular FIFO with count; flush beats push, push+pop when full both proceed.
module mailbox_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic             doPush, doPop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rdPtr];

    // A pop from a full FIFO frees the slot the same-cycle push lands in.
    assign doPush = push & ~flush & (~full | pop);
    assign doPop  = pop & ~flush & ~empty;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (doPush) mem[wrPtr] <= din;
    end

endmodule

// File: rtl/sdx_mailbox_fifo.sv
// Host/client mailbox: H2C FIFO {cmd,byte}, C2H FIFO byte, synchronised
// strobe edges commit pushes/pops, reads are combinational from raw strobes.
module sdx_mailbox_fifo
    import sdx_mailbox_pkg::*;
#(
    parameter int         DEPTH     = 4,
    parameter logic [4:0] PORT_BASE = 5'b11000,
    parameter logic [7:0] VERSION   = 8'h20,
    parameter logic [7:0] DETECT_ID = DEFAULT_DETECT_ID
) (
    input logic               Clock,
    input logic               Reset,
    sdx_mailbox_fifo_if.slave mbx
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [NUM_STB-1:0] strobeRaw, stbRise, stbFall;
    logic [1:0]         vldPipe;

    assign strobeRaw[STB_HOST_RD] = ~mbx.nIN;
    assign strobeRaw[STB_HOST_WR] = ~mbx.nOUT;
    assign strobeRaw[STB_CLI_RD]  = mbx.ClientReadLine;
    assign strobeRaw[STB_CLI_WR]  = mbx.ClientWriteLine;

    // vldPipe[1] marks when the synchroniser output reflects post-reset input.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) vldPipe <= '0;
        else       vldPipe <= {vldPipe[0], 1'b1};
    end

    // Edges are only reported once the strobe has been seen idle after reset,
    // so an access held across reset release is ignored entirely.
    for (genvar g = 0; g < NUM_STB; g++) begin : g_sync
        logic [1:0] syncFf;
        logic       edgeFf, armed;
        always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
                syncFf <= '0;
                edgeFf <= 1'b0;
                armed  <= 1'b0;
            end else begin
                syncFf <= {syncFf[0], strobeRaw[g]};
                edgeFf <= syncFf[1];
                armed  <= armed | (vldPipe[1] & ~syncFf[1]);
            end
        end
        assign stbRise[g] = armed & syncFf[1] & ~edgeFf;
        assign stbFall[g] = armed & ~syncFf[1] & edgeFf;
    end

    logic       hostHit;
    logic [2:0] hostOff;
    assign hostHit = (mbx.HostAddressBus[7:3] == PORT_BASE);
    assign hostOff = mbx.HostAddressBus[2:0];

    // Read decode is captured at the rising edge; the address is gone by the pop.
    logic       rdHit, cliRdStat;
    logic [2:0] rdOff;
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rdHit     <= 1'b0;
            rdOff     <= '0;
            cliRdStat <= 1'b0;
        end else begin
            if (stbRise[STB_HOST_RD]) begin
                rdHit <= hostHit;
                rdOff <= hostOff;
            end
            if (stbRise[STB_CLI_RD]) cliRdStat <= mbx.ClientStatusLine;
        end
    end

    logic             h2cPush, h2cPop, h2cFlush, h2cFull, h2cEmpty;
    logic             c2hPush, c2hPop, c2hFlush, c2hFull, c2hEmpty;
    logic [8:0]       h2cDin, h2cHead;
    logic [7:0]       c2hHead;
    logic [CNT_W-1:0] h2cCount, c2hCount;
    logic             cliStatWr, hostOvfClr, cliOvfClr, h2cDrop, c2hDrop;

    assign h2cPush    = stbRise[STB_HOST_WR] & hostHit &
                        (hostOff == OFF_WR_CMD || hostOff == OFF_WR_DATA);
    assign h2cDin     = {hostOff == OFF_WR_CMD, mbx.HostDataIn};
    assign c2hPop     = stbFall[STB_HOST_RD] & rdHit & (rdOff == OFF_RD_DATA);
    assign hostOvfClr = stbFall[STB_HOST_RD] & rdHit & (rdOff == OFF_STATUS);

    assign c2hPush    = stbRise[STB_CLI_WR] & ~mbx.ClientStatusLine;
    assign cliStatWr  = stbRise[STB_CLI_WR] & mbx.ClientStatusLine;
    assign h2cPop     = stbFall[STB_CLI_RD] & ~cliRdStat;
    assign cliOvfClr  = stbFall[STB_CLI_RD] & cliRdStat;
    assign h2cFlush   = cliStatWr & mbx.ClientDataIn[0];
    assign c2hFlush   = cliStatWr & mbx.ClientDataIn[1];

    assign h2cDrop = h2cPush & h2cFull & ~h2cPop & ~h2cFlush;
    assign c2hDrop = c2hPush & c2hFull & ~c2hPop & ~c2hFlush;

    mailbox_fifo #(.WIDTH(9), .DEPTH(DEPTH)) uH2c (
        .Clock(Clock), .Reset(Reset),
        .push(h2cPush), .pop(h2cPop), .flush(h2cFlush), .din(h2cDin),
        .head(h2cHead), .count(h2cCount), .full(h2cFull), .empty(h2cEmpty)
    );

    mailbox_fifo #(.WIDTH(8), .DEPTH(DEPTH)) uC2h (
        .Clock(Clock), .Reset(Reset),
        .push(c2hPush), .pop(c2hPop), .flush(c2hFlush), .din(mbx.ClientDataIn),
        .head(c2hHead), .count(c2hCount), .full(c2hFull), .empty(c2hEmpty)
    );

    logic [3:0] top4;
    logic       hostOvf, cliOvf, irqReg;

    // Set beats clear when an overflow lands on the status-read pop cycle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            top4    <= '0;
            hostOvf <= 1'b0;
            cliOvf  <= 1'b0;
            irqReg  <= 1'b0;
        end else begin
            if (cliStatWr) top4 <= mbx.ClientDataIn[7:4];
            hostOvf <= h2cDrop | (hostOvf & ~hostOvfClr);
            cliOvf  <= c2hDrop | (cliOvf & ~cliOvfClr);
            irqReg  <= ~h2cEmpty;
        end
    end
    assign mbx.ClientIrq = irqReg;

    logic       headCmd;
    logic [6:0] h2cCnt7;
    logic [7:0] hostStatus, cliStatus, hostData;

    assign headCmd = ~h2cEmpty & h2cHead[8];
    assign h2cCnt7 = 7'(h2cCount);

    always_comb begin
        hostStatus                           = '0;
        hostStatus[HS_H2C_FULL]              = h2cFull;
        hostStatus[HS_C2H_NE]                = (c2hCount != '0);
        hostStatus[HS_HEAD_CMD]              = headCmd;
        hostStatus[HS_OVF]                   = hostOvf;
        hostStatus[HS_TOP4_LSB +: 4]         = top4;
        cliStatus                            = '0;
        cliStatus[CS_H2C_NE]                 = ~h2cEmpty;
        cliStatus[CS_C2H_FULL]               = c2hFull;
        cliStatus[CS_HEAD_CMD]               = headCmd;
        cliStatus[CS_OVF]                    = cliOvf;
        cliStatus[CS_CNT_LSB +: 4]           = satCount4(h2cCnt7);
    end

    always_comb begin
        hostData = EMPTY_READ;
        case (hostOff)
            OFF_RD_DATA: hostData = c2hEmpty ? EMPTY_READ : c2hHead;
            OFF_STATUS:  hostData = hostStatus;
            OFF_DETECT:  hostData = DETECT_ID;
            OFF_VERSION: hostData = VERSION;
            default:     hostData = EMPTY_READ;
        endcase
    end

    assign mbx.HostDataOut   = hostData;
    assign mbx.HostDataOE    = hostHit & ~mbx.nIN &
                               (hostOff == OFF_RD_DATA || hostOff == OFF_STATUS ||
                                hostOff == OFF_DETECT  || hostOff == OFF_VERSION);
    assign mbx.ClientDataOut = mbx.ClientStatusLine ? cliStatus :
                               (h2cEmpty ? EMPTY_READ : h2cHead[7:0]);
    assign mbx.ClientDataOE  = mbx.ClientReadLine;

endmodule

// File: tb/tb_sdx_mailbox_fifo.sv
// Bench for sdx_mailbox_fifo: vector table, directed corner sequences, and
// random traffic checked against a queue-based model.
module tb_sdx_mailbox_fifo;
    import sdx_mailbox_pkg::*;

    localparam int         DEPTH = 4;
    localparam logic [4:0] PB    = 5'b11000;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    sdx_mailbox_fifo_if bus ();

    sdx_mailbox_fifo #(
        .DEPTH(DEPTH), .PORT_BASE(PB), .VERSION(8'h20), .DETECT_ID(8'd42)
    ) dut (
        .Clock(Clock), .Reset(Reset), .mbx(bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", name, act, exp);
        end
    endtask

    task automatic waitCyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic idleBus();
        bus.HostAddressBus   = 8'h00;
        bus.nIN              = 1'b1;
        bus.nOUT             = 1'b1;
        bus.HostDataIn       = 8'h00;
        bus.ClientReadLine   = 1'b0;
        bus.ClientWriteLine  = 1'b0;
        bus.ClientStatusLine = 1'b0;
        bus.ClientDataIn     = 8'h00;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        idleBus();
        waitCyc(3);
        Reset = 1'b0;
        waitCyc(4);
    endtask

    task automatic hostRead(input logic [2:0] off, output logic [7:0] d, output logic oe);
        bus.HostAddressBus = {PB, off};
        bus.nIN = 1'b0;
        waitCyc(5);
        d  = bus.HostDataOut;
        oe = bus.HostDataOE;
        bus.nIN = 1'b1;
        waitCyc(5);
    endtask

    task automatic hostWrite(input logic [2:0] off, input logic [7:0] d);
        bus.HostAddressBus = {PB, off};
        bus.HostDataIn = d;
        bus.nOUT = 1'b0;
        waitCyc(5);
        bus.nOUT = 1'b1;
        waitCyc(5);
    endtask

    task automatic clientRead(input logic st, output logic [7:0] d);
        bus.ClientStatusLine = st;
        bus.ClientReadLine = 1'b1;
        waitCyc(5);
        d = bus.ClientDataOut;
        bus.ClientReadLine = 1'b0;
        waitCyc(5);
        bus.ClientStatusLine = 1'b0;
    endtask

    task automatic clientWrite(input logic st, input logic [7:0] d);
        bus.ClientStatusLine = st;
        bus.ClientDataIn = d;
        bus.ClientWriteLine = 1'b1;
        waitCyc(5);
        bus.ClientWriteLine = 1'b0;
        waitCyc(5);
        bus.ClientStatusLine = 1'b0;
    endtask

    typedef enum logic [2:0] {OP_HR, OP_HW, OP_CR, OP_CS, OP_CW, OP_CSW} op_e;
    typedef struct {
        op_e        op;
        logic [2:0] off;
        logic [7:0] data;
        logic       chk;
        logic [7:0] exp;
        logic       expIrq;
    } vec_t;

    vec_t vecs[15];

    // Reference model for the random phase.
    logic [8:0] mH2c[$];
    logic [7:0] mC2h[$];
    logic       mHostOvf, mCliOvf;
    logic [3:0] mTop4;

    function automatic logic [7:0] mHostStat();
        logic hc;
        hc = (mH2c.size() != 0) ? mH2c[0][8] : 1'b0;
        return {mTop4, mHostOvf, hc, mC2h.size() != 0, mH2c.size() == DEPTH};
    endfunction

    function automatic logic [7:0] mCliStat();
        int   n;
        logic hc;
        n  = (mH2c.size() > 15) ? 15 : mH2c.size();
        hc = (mH2c.size() != 0) ? mH2c[0][8] : 1'b0;
        return {4'(n), mCliOvf, hc, mC2h.size() == DEPTH, mH2c.size() != 0};
    endfunction

    logic [7:0] d, e;
    logic       oe;

    initial begin
        vecs[0]  = '{OP_HR,  3'd4, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[1]  = '{OP_HR,  3'd6, 8'h00, 1'b1, 8'd42, 1'b0};
        vecs[2]  = '{OP_HR,  3'd7, 8'h00, 1'b1, 8'h20, 1'b0};
        vecs[3]  = '{OP_HW,  3'd5, 8'h77, 1'b0, 8'h00, 1'b0};
        vecs[4]  = '{OP_CS,  3'd0, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[5]  = '{OP_HW,  3'd0, 8'h55, 1'b0, 8'h00, 1'b1};
        vecs[6]  = '{OP_HW,  3'd1, 8'hAA, 1'b0, 8'h00, 1'b1};
        vecs[7]  = '{OP_CS,  3'd0, 8'h00, 1'b1, 8'h25, 1'b1};
        vecs[8]  = '{OP_HR,  3'd4, 8'h00, 1'b1, 8'h04, 1'b1};
        vecs[9]  = '{OP_CR,  3'd0, 8'h00, 1'b1, 8'h55, 1'b1};
        vecs[10] = '{OP_CS,  3'd0, 8'h00, 1'b1, 8'h11, 1'b1};
        vecs[11] = '{OP_CR,  3'd0, 8'h00, 1'b1, 8'hAA, 1'b0};
        vecs[12] = '{OP_CR,  3'd0, 8'h00, 1'b1, 8'hFF, 1'b0};
        vecs[13] = '{OP_HR,  3'd2, 8'h00, 1'b1, 8'hFF, 1'b0};
        vecs[14] = '{OP_HR,  3'd4, 8'h00, 1'b1, 8'h00, 1'b0};

        idleBus();
        waitCyc(1);
        check("reset_irq", {7'd0, bus.ClientIrq}, 8'h00);
        doReset();

        for (int i = 0; i < 15; i++) begin
            d = 8'h00;
            case (vecs[i].op)
                OP_HR:   hostRead(vecs[i].off, d, oe);
                OP_HW:   hostWrite(vecs[i].off, vecs[i].data);
                OP_CR:   clientRead(1'b0, d);
                OP_CS:   clientRead(1'b1, d);
                OP_CW:   clientWrite(1'b0, vecs[i].data);
                default: clientWrite(1'b1, vecs[i].data);
            endcase
            if (vecs[i].chk) check($sformatf("vec%0d_data", i), d, vecs[i].exp);
            check($sformatf("vec%0d_irq", i), {7'd0, bus.ClientIrq}, {7'd0, vecs[i].expIrq});
        end

        hostRead(3'd3, d, oe);
        check("ignored_off_oe", {7'd0, oe}, 8'h00);

        // C2H overflow then drain from the host side.
        for (int i = 0; i <= DEPTH; i++) clientWrite(1'b0, 8'(i));
        clientRead(1'b1, d);
        check("c2h_ovf_cstat", d, 8'h0A);
        hostRead(3'd4, d, oe);
        check("c2h_ovf_hstat", d, 8'h02);
        for (int i = 0; i < DEPTH; i++) begin
            hostRead(3'd2, d, oe);
            check($sformatf("c2h_drain%0d", i), d, 8'(i));
        end
        hostRead(3'd2, d, oe);
        check("c2h_empty_read", d, 8'hFF);
        hostRead(3'd4, d, oe);
        check("c2h_drained_hstat", d, 8'h00);
        clientRead(1'b1, d);
        check("cliovf_cleared", d, 8'h00);

        // Full H2C: host push and client pop committing in the same cycle.
        for (int i = 0; i < DEPTH; i++) hostWrite(3'd1, 8'h10 + 8'(i));
        clientRead(1'b1, d);
        check("h2c_full_cstat", d, 8'h41);
        bus.ClientReadLine = 1'b1;
        waitCyc(5);
        check("overlap_head", bus.ClientDataOut, 8'h10);
        bus.HostAddressBus = {PB, 3'd1};
        bus.HostDataIn = 8'h77;
        bus.ClientReadLine = 1'b0;
        bus.nOUT = 1'b0;
        waitCyc(5);
        bus.nOUT = 1'b1;
        waitCyc(5);
        hostRead(3'd4, d, oe);
        check("overlap_hstat", d, 8'h01);
        clientRead(1'b1, d);
        check("overlap_cstat", d, 8'h41);
        for (int i = 0; i < DEPTH; i++) begin
            clientRead(1'b0, d);
            check($sformatf("overlap_order%0d", i), d, (i == DEPTH - 1) ? 8'h77 : 8'h11 + 8'(i));
        end
        check("overlap_irq", {7'd0, bus.ClientIrq}, 8'h00);

        // Status write A3 racing a host push: both flushes win.
        hostWrite(3'd0, 8'h31);
        clientWrite(1'b0, 8'h44);
        bus.HostAddressBus = {PB, 3'd1};
        bus.HostDataIn = 8'h99;
        bus.ClientStatusLine = 1'b1;
        bus.ClientDataIn = 8'hA3;
        bus.nOUT = 1'b0;
        bus.ClientWriteLine = 1'b1;
        waitCyc(5);
        bus.nOUT = 1'b1;
        bus.ClientWriteLine = 1'b0;
        waitCyc(5);
        bus.ClientStatusLine = 1'b0;
        hostRead(3'd4, d, oe);
        check("flush_hstat", d, 8'hA0);
        clientRead(1'b1, d);
        check("flush_cstat", d, 8'h00);
        clientRead(1'b0, d);
        check("flush_h2c_empty", d, 8'hFF);
        check("flush_irq", {7'd0, bus.ClientIrq}, 8'h00);

        // Reset in the middle of a host data read.
        for (int i = 0; i < 3; i++) clientWrite(1'b0, 8'h61 + 8'(i));
        bus.HostAddressBus = {PB, 3'd2};
        bus.nIN = 1'b0;
        waitCyc(5);
        check("rst_read_before", bus.HostDataOut, 8'h61);
        Reset = 1'b1;
        waitCyc(1);
        check("rst_oe_follows", {7'd0, bus.HostDataOE}, 8'h01);
        check("rst_read_during", bus.HostDataOut, 8'hFF);
        waitCyc(2);
        Reset = 1'b0;
        waitCyc(6);
        bus.nIN = 1'b1;
        waitCyc(6);
        hostRead(3'd4, d, oe);
        check("rst_hstat", d, 8'h00);
        clientWrite(1'b0, 8'h5A);
        hostRead(3'd2, d, oe);
        check("rst_no_spurious_pop", d, 8'h5A);
        hostRead(3'd2, d, oe);
        check("rst_c2h_empty", d, 8'hFF);
        hostRead(3'd6, d, oe);
        check("rst_detect", d, 8'd42);

        // Random traffic against the queue model.
        doReset();
        mH2c.delete();
        mC2h.delete();
        mHostOvf = 1'b0;
        mCliOvf  = 1'b0;
        mTop4    = 4'h0;
        for (int n = 0; n < 250; n++) begin
            int         op;
            logic [7:0] r;
            op = $urandom_range(0, 9);
            r  = 8'($urandom);
            case (op)
                0, 1: begin
                    hostWrite(3'(op), r);
                    if (mH2c.size() == DEPTH) mHostOvf = 1'b1;
                    else mH2c.push_back({op == 0, r});
                end
                2: begin
                    e = (mC2h.size() != 0) ? mC2h[0] : 8'hFF;
                    hostRead(3'd2, d, oe);
                    check($sformatf("rnd%0d_hdata", n), d, e);
                    if (mC2h.size() != 0) void'(mC2h.pop_front());
                end
                3: begin
                    e = mHostStat();
                    hostRead(3'd4, d, oe);
                    check($sformatf("rnd%0d_hstat", n), d, e);
                    mHostOvf = 1'b0;
                end
                4, 5: begin
                    clientWrite(1'b0, r);
                    if (mC2h.size() == DEPTH) mCliOvf = 1'b1;
                    else mC2h.push_back(r);
                end
                6: begin
                    e = (mH2c.size() != 0) ? mH2c[0][7:0] : 8'hFF;
                    clientRead(1'b0, d);
                    check($sformatf("rnd%0d_cdata", n), d, e);
                    if (mH2c.size() != 0) void'(mH2c.pop_front());
                end
                7: begin
                    e = mCliStat();
                    clientRead(1'b1, d);
                    check($sformatf("rnd%0d_cstat", n), d, e);
                    mCliOvf = 1'b0;
                end
                8: begin
                    r[0] = ($urandom_range(0, 4) == 0);
                    r[1] = ($urandom_range(0, 4) == 0);
                    clientWrite(1'b1, r);
                    mTop4 = r[7:4];
                    if (r[0]) mH2c.delete();
                    if (r[1]) mC2h.delete();
                end
                default: begin
                    hostRead(r[0] ? 3'd6 : 3'd7, d, oe);
                    check($sformatf("rnd%0d_id", n), d, r[0] ? 8'd42 : 8'h20);
                end
            endcase
            check($sformatf("rnd%0d_irq", n), {7'd0, bus.ClientIrq}, {7'd0, mH2c.size() != 0});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
